// File: rtl/tick_gen_pkg.sv
// Shared mode encoding, reset defaults and sizing helpers for the tick generator.
package tick_gen_pkg;

    typedef enum logic [1:0] {
        MODE_PERIODIC = 2'b00,
        MODE_SQUARE   = 2'b01,
        MODE_ONESHOT  = 2'b10
    } mode_e;

    localparam logic [23:0] TG_DEFAULT_PERIOD = 24'h0F_FFFF;
    localparam logic [1:0]  TG_DEFAULT_MODE   = 2'b00;

    // Width of a channel index; a single-channel build still gets a 1-bit select.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // The reserved encoding 2'b11 behaves exactly like periodic.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        mode_e m;
        case (raw)
            2'b01:   m = MODE_SQUARE;
            2'b10:   m = MODE_ONESHOT;
            default: m = MODE_PERIODIC;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tick_gen_ch.sv
// One tick channel: programmable period and mode, a counter, and registered
// tick / square / busy outputs.
module tick_gen_ch
    import tick_gen_pkg::*;
#(
    parameter int               CNT_W          = 24,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(TG_DEFAULT_PERIOD),
    parameter logic [1:0]       DEFAULT_MODE   = TG_DEFAULT_MODE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pause,
    input  logic             restart,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_period,
    input  logic [1:0]       wr_mode,
    output logic             tick,
    output logic             sq,
    output logic             busy
);

    localparam mode_e RST_MODE = decode_mode(DEFAULT_MODE);

    logic [CNT_W-1:0] period_q, period_d;
    mode_e            mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             busy_q, busy_d;
    logic             finished;
    logic             running;
    logic             expire;

    always_comb begin
        // NOTE: every signal gets a default first, so no branch leaves one unassigned and no latch is inferred.
        period_d = period_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        tick_d   = 1'b0;
        sq_d     = sq_q;
        busy_d   = busy_q;

        finished = (mode_q == MODE_ONESHOT) && !busy_q;
        running  = en && !pause && !finished;
        expire   = (cnt_q == period_q);

        if (wr) begin
            period_d = wr_period;
            mode_d   = decode_mode(wr_mode);
        end

        // Restart and config writes outrank expiry, so no tick escapes in that cycle.
        if (restart || wr) begin
            cnt_d  = '0;
            sq_d   = 1'b0;
            busy_d = (mode_d == MODE_ONESHOT);
        end else if (running) begin
            if (expire) begin
                cnt_d = '0;
                case (mode_q)
                    MODE_SQUARE: begin
                        sq_d = ~sq_q;
                    end
                    MODE_ONESHOT: begin
                        tick_d = 1'b1;
                        busy_d = 1'b0;
                    end
                    default: begin
                        tick_d = 1'b1;
                    end
                endcase
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state uses <= so every flop samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_q <= DEFAULT_PERIOD;
            mode_q   <= RST_MODE;
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            sq_q     <= 1'b0;
            busy_q   <= (RST_MODE == MODE_ONESHOT);
        end else begin
            period_q <= period_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            sq_q     <= sq_d;
            busy_q   <= busy_d;
        end
    end

    assign tick = tick_q;
    assign sq   = sq_q;
    assign busy = busy_q;

endmodule

// File: rtl/tick_gen.sv
// Multi-channel tick / clock-enable generator: config decode, bad-channel
// error pulse, reset-release synchronisation and the channel array.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int               NUM_CH         = 4,
    parameter int               CNT_W          = 24,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(TG_DEFAULT_PERIOD),
    parameter logic [1:0]       DEFAULT_MODE   = TG_DEFAULT_MODE,
    localparam int              CH_W           = ch_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NUM_CH-1:0] pause,
    input  logic              sync_restart,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [1:0]        cfg_mode,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq,
    output logic [NUM_CH-1:0] busy,
    output logic              cfg_err
);

    localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

    logic [1:0]        rst_sync_q, rst_sync_d;
    logic              rst_int;
    logic              cfg_valid;
    logic              cfg_err_q, cfg_err_d;
    logic [NUM_CH-1:0] ch_wr;

    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b0};
    end

    // NOTE: reset asserts immediately but releases two clk edges later, so no flop leaves reset near an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign rst_int = rst_sync_q[1];

    always_comb begin
        ch_wr     = '0;
        cfg_valid = ({1'b0, cfg_ch} < NUM_CH_L);
        cfg_err_d = cfg_we && !cfg_valid;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_wr[i] = cfg_we && cfg_valid && (cfg_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tick_gen_ch #(
            .CNT_W          (CNT_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD),
            .DEFAULT_MODE   (DEFAULT_MODE)
        ) u_ch (
            .clk       (clk),
            .rst       (rst_int),
            .en        (en),
            .pause     (pause[g]),
            .restart   (sync_restart),
            .wr        (ch_wr[g]),
            .wr_period (cfg_period),
            .wr_mode   (cfg_mode),
            .tick      (tick[g]),
            .sq        (sq[g]),
            .busy      (busy[g])
        );
    end

endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen: a cycle model pushes expected outputs to a
// scoreboard queue, popped and compared one clock later, plus directed timing checks.
`timescale 1ns/1ps
module tb_tick_gen;

    localparam int               NUM_CH = 5;
    localparam int               CNT_W  = 8;
    localparam int               CH_W   = 3;
    localparam logic [CNT_W-1:0] DEF_N  = 8'd9;

    logic              clk          = 1'b0;
    logic              rst          = 1'b0;
    logic              en           = 1'b0;
    logic [NUM_CH-1:0] pause        = '0;
    logic              sync_restart = 1'b0;
    logic              cfg_we       = 1'b0;
    logic [CH_W-1:0]   cfg_ch       = '0;
    logic [CNT_W-1:0]  cfg_period   = '0;
    logic [1:0]        cfg_mode     = '0;
    logic [NUM_CH-1:0] tick, sq, busy;
    logic              cfg_err;

    always #5 clk = ~clk;

    tick_gen #(
        .NUM_CH         (NUM_CH),
        .CNT_W          (CNT_W),
        .DEFAULT_PERIOD (DEF_N),
        .DEFAULT_MODE   (2'b00)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .pause        (pause),
        .sync_restart (sync_restart),
        .cfg_we       (cfg_we),
        .cfg_ch       (cfg_ch),
        .cfg_period   (cfg_period),
        .cfg_mode     (cfg_mode),
        .tick         (tick),
        .sq           (sq),
        .busy         (busy),
        .cfg_err      (cfg_err)
    );

    typedef struct packed {
        logic [NUM_CH-1:0] tick;
        logic [NUM_CH-1:0] sq;
        logic [NUM_CH-1:0] busy;
        logic              err;
    } exp_t;

    exp_t sb_q[$];

    int unsigned       m_per [NUM_CH];
    int unsigned       m_c   [NUM_CH];
    logic [1:0]        m_mode[NUM_CH];
    logic [NUM_CH-1:0] m_tick, m_sq, m_busy;
    logic              m_err;
    logic [1:0]        m_rs;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s (cycle %0d): observed 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_per[i]  = DEF_N;
            m_c[i]    = 0;
            m_mode[i] = 2'b00;
        end
        m_tick = '0;
        m_sq   = '0;
        m_busy = '0;
        m_err  = 1'b0;
        m_rs   = 2'b11;
    endtask

    // Behaviour of one clock edge, taken from the current input values.
    task automatic model_step();
        logic in_rst;
        logic wr;
        logic tk;
        in_rst = m_rs[1];
        if (rst) begin
            model_reset();
            return;
        end
        if (!in_rst) begin
            m_err = cfg_we && (int'(cfg_ch) >= NUM_CH);
            for (int i = 0; i < NUM_CH; i++) begin
                wr = cfg_we && (int'(cfg_ch) == i);
                tk = 1'b0;
                if (wr) begin
                    m_per[i]  = cfg_period;
                    m_mode[i] = (cfg_mode == 2'b11) ? 2'b00 : cfg_mode;
                end
                if (sync_restart || wr) begin
                    m_c[i]    = 0;
                    m_sq[i]   = 1'b0;
                    m_busy[i] = (m_mode[i] == 2'b10);
                end else if (en && !pause[i] && !(m_mode[i] == 2'b10 && !m_busy[i])) begin
                    if (m_c[i] == m_per[i]) begin
                        m_c[i] = 0;
                        if (m_mode[i] == 2'b01) begin
                            m_sq[i] = ~m_sq[i];
                        end else begin
                            tk = 1'b1;
                            if (m_mode[i] == 2'b10) m_busy[i] = 1'b0;
                        end
                    end else begin
                        m_c[i]++;
                    end
                end
                m_tick[i] = tk;
            end
        end
        m_rs = {m_rs[0], 1'b0};
    endtask

    // One clock: predict, push, clock, pop and compare all outputs.
    task automatic cycle();
        exp_t e;
        model_step();
        e.tick = m_tick;
        e.sq   = m_sq;
        e.busy = m_busy;
        e.err  = m_err;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = sb_q.pop_front();
        check("sb_tick",    32'(tick),    32'(e.tick));
        check("sb_sq",      32'(sq),      32'(e.sq));
        check("sb_busy",    32'(busy),    32'(e.busy));
        check("sb_cfg_err", 32'(cfg_err), 32'(e.err));
    endtask

    // Clocks until tick[ch] is high (or sq[ch] changes); n = cycles taken, -1 on timeout.
    task automatic run_until(input int ch, input bit on_sq, input int max_cyc, output int n);
        logic start;
        start = sq[ch];
        n = -1;
        for (int k = 1; k <= max_cyc; k++) begin
            cycle();
            if (on_sq ? (sq[ch] !== start) : (tick[ch] === 1'b1)) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic cfg_write(input int ch, input int period, input logic [1:0] mode);
        cfg_we     = 1'b1;
        cfg_ch     = CH_W'(ch);
        cfg_period = CNT_W'(period);
        cfg_mode   = mode;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int extra;

        model_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_async_tick", 32'(tick),    32'd0);
        check("rst_async_busy", 32'(busy),    32'd0);
        check("rst_async_err",  32'(cfg_err), 32'd0);
        repeat (3) cycle();
        rst = 1'b0;
        repeat (3) cycle();

        // Periodic N=3: first tick 4 cycles after the write edge, then every 4.
        en = 1'b1;
        cfg_write(0, 3, 2'b00);
        cycle();
        cfg_we = 1'b0;
        run_until(0, 1'b0, 20, n);
        check("ch0_first_tick", 32'(n), 32'd4);
        run_until(0, 1'b0, 20, n);
        check("ch0_tick_period", 32'(n), 32'd4);

        // Square N=2: sq toggles every 3 cycles.
        cfg_write(1, 2, 2'b01);
        cycle();
        cfg_we = 1'b0;
        run_until(1, 1'b1, 20, n);
        check("ch1_sq_first", 32'(n), 32'd3);
        run_until(1, 1'b1, 20, n);
        check("ch1_sq_half", 32'(n), 32'd3);

        // One-shot N=5: fires once, stays quiet, re-arms on sync_restart.
        cfg_write(2, 5, 2'b10);
        cycle();
        cfg_we = 1'b0;
        check("ch2_armed", 32'(busy[2]), 32'd1);
        run_until(2, 1'b0, 20, n);
        check("ch2_fire", 32'(n), 32'd6);
        check("ch2_done", 32'(busy[2]), 32'd0);
        extra = 0;
        repeat (12) begin
            cycle();
            extra += int'(tick[2]);
        end
        check("ch2_no_refire", 32'(extra), 32'd0);
        sync_restart = 1'b1;
        cycle();
        sync_restart = 1'b0;
        check("ch2_rearmed", 32'(busy[2]), 32'd1);
        run_until(2, 1'b0, 20, n);
        check("ch2_refire", 32'(n), 32'd6);

        // Pause ch0 (N=7) at c=4 for 10 cycles; resumes 4 cycles after release.
        cfg_write(0, 7, 2'b00);
        cycle();
        cfg_we = 1'b0;
        repeat (4) cycle();
        pause[0] = 1'b1;
        extra = 0;
        repeat (10) begin
            cycle();
            extra += int'(tick[0]);
        end
        check("ch0_paused_ticks", 32'(extra), 32'd0);
        pause[0] = 1'b0;
        run_until(0, 1'b0, 20, n);
        check("ch0_resume", 32'(n), 32'd4);

        // ch0 is one edge from expiry: restart plus write to ch3 wins.
        repeat (7) cycle();
        sync_restart = 1'b1;
        cfg_write(3, 1, 2'b00);
        cycle();
        sync_restart = 1'b0;
        cfg_we       = 1'b0;
        check("ch0_restart_no_tick", 32'(tick[0]), 32'd0);
        run_until(3, 1'b0, 10, n);
        check("ch3_first", 32'(n), 32'd2);
        run_until(3, 1'b0, 10, n);
        check("ch3_period", 32'(n), 32'd2);

        // A write while paused applies but the channel stays held.
        pause[1] = 1'b1;
        cfg_write(1, 4, 2'b00);
        cycle();
        cfg_we = 1'b0;
        extra  = 0;
        repeat (5) begin
            cycle();
            extra += int'(tick[1]);
        end
        check("ch1_paused_write", 32'(extra), 32'd0);
        pause[1] = 1'b0;
        run_until(1, 1'b0, 20, n);
        check("ch1_after_pause", 32'(n), 32'd5);

        // Global run low freezes every channel.
        en    = 1'b0;
        extra = 0;
        repeat (6) begin
            cycle();
            extra += int'(|tick);
        end
        check("en_low_ticks", 32'(extra), 32'd0);
        en = 1'b1;
        repeat (3) cycle();

        // Out-of-range channel writes: one-cycle error, no state change.
        cfg_write(5, 2, 2'b01);
        cycle();
        cfg_we = 1'b0;
        check("cfg_err_pulse", 32'(cfg_err), 32'd1);
        cycle();
        check("cfg_err_clear", 32'(cfg_err), 32'd0);
        cfg_write(7, 0, 2'b10);
        cycle();
        cfg_we = 1'b0;
        check("cfg_err_ch7", 32'(cfg_err), 32'd1);

        // Reserved mode behaves as periodic.
        cfg_write(4, 1, 2'b11);
        cycle();
        cfg_we = 1'b0;
        check("ch4_rsvd_busy", 32'(busy[4]), 32'd0);
        run_until(4, 1'b0, 10, n);
        check("ch4_rsvd_tick", 32'(n), 32'd2);

        // Mid-count reset clears outputs at once and restores defaults.
        cfg_write(2, 20, 2'b10);
        cycle();
        cfg_write(1, 1, 2'b01);
        cycle();
        cfg_we = 1'b0;
        repeat (3) cycle();
        check("pre_rst_busy2", 32'(busy[2]), 32'd1);
        rst = 1'b1;
        #2;
        check("mid_rst_tick", 32'(tick),    32'd0);
        check("mid_rst_sq",   32'(sq),      32'd0);
        check("mid_rst_busy", 32'(busy),    32'd0);
        check("mid_rst_err",  32'(cfg_err), 32'd0);
        model_reset();
        repeat (2) cycle();
        rst = 1'b0;
        run_until(0, 1'b0, 30, n);
        check("default_period_restored", 32'(n), 32'd12);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
